// File: rtl/serial_word_tx.sv
// Word-to-bit serializer: start bit, WIDTH data bits MSB first, stop bit.
// Counts completed frames; back-to-back words are taken in the STOP cycle.
module serial_word_tx #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             busy,
    output logic [31:0]      frame_cnt
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    bcnt, bcnt_nxt;
    logic             ser_out_nxt, ser_frame_nxt, busy_nxt;
    logic             accept;

    // in_ready depends on state only, so upstream may gate valid on it freely
    assign in_ready = (state == IDLE) || (state == STOP);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            bcnt      <= '0;
            ser_out   <= 1'b0;
            ser_frame <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            bcnt      <= bcnt_nxt;
            ser_out   <= ser_out_nxt;
            ser_frame <= ser_frame_nxt;
            busy      <= busy_nxt;
            if (state == STOP)
                frame_cnt <= frame_cnt + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        bcnt_nxt  = bcnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = in_data;
                    state_nxt = START;
                end
            end
            START: begin
                bcnt_nxt  = '0;
                state_nxt = DATA;
            end
            DATA: begin
                sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                bcnt_nxt = bcnt + CW'(1);
                if (bcnt == LAST)
                    state_nxt = STOP;
            end
            STOP: begin
                if (accept) begin
                    sreg_nxt  = in_data;
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the state being entered
    always_comb begin
        ser_out_nxt   = 1'b0;
        ser_frame_nxt = 1'b0;
        busy_nxt      = 1'b0;
        case (state_nxt)
            START: begin
                ser_out_nxt = 1'b1;
                busy_nxt    = 1'b1;
            end
            DATA: begin
                ser_out_nxt   = sreg_nxt[WIDTH-1];
                ser_frame_nxt = 1'b1;
                busy_nxt      = 1'b1;
            end
            STOP:    busy_nxt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: frame shape, back-to-back, held valid,
// mid-frame reset and frame counter wrap.
module tb_serial_word_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        ser_out, ser_frame, busy;
    logic [31:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [67:0] bits;
    int          frm, nrdy;

    serial_word_tx #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ser_out(ser_out), .ser_frame(ser_frame),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present a word at a negedge; returns at the negedge after acceptance (START cycle)
    task automatic send_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sample n cycles at negedges; optionally change in_data and drop in_valid
    task automatic capture(input int n, input int chg_at, input logic [31:0] chg_data,
                           input int drop_at, output logic [67:0] b, output int f, output int nr);
        b = '0; f = 0; nr = 0;
        for (int i = 0; i < n; i++) begin
            b = {b[66:0], ser_out};
            if (ser_frame) f++;
            if (!in_ready) nr++;
            if (i == chg_at) in_data = chg_data;
            if (i == drop_at) in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_ser_out",   68'(ser_out),   68'd0);
        chk("rst_busy",      68'(busy),      68'd0);
        chk("rst_frame",     68'(ser_frame), 68'd0);
        chk("rst_frame_cnt", 68'(frame_cnt), 68'd0);
        chk("rst_in_ready",  68'(in_ready),  68'd1);

        // Single frame
        send_word(32'hA5A5_0F0F);
        capture(34, -1, '0, 0, bits, frm, nrdy);
        chk("single_bits",   bits, 68'({1'b1, 32'b1010_0101_1010_0101_0000_1111_0000_1111, 1'b0}));
        chk("single_frame",  68'(frm),  68'd32);
        chk("single_nrdy",   68'(nrdy), 68'd33);
        chk("single_cnt",    68'(frame_cnt), 68'd1);
        chk("single_idle",   68'(busy), 68'd0);

        // Back-to-back with valid held high
        do_reset();
        send_word(32'h0000_0001);
        capture(68, 0, 32'hFFFF_FFFF, 34, bits, frm, nrdy);
        chk("b2b_bits",  bits, {1'b1, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0});
        chk("b2b_frame", 68'(frm), 68'd64);
        chk("b2b_cnt",   68'(frame_cnt), 68'd2);

        // Data changes while busy; value present at STOP is the next word
        do_reset();
        send_word(32'h1234_5678);
        capture(68, 5, 32'hCAFE_F00D, 34, bits, frm, nrdy);
        chk("held_bits", bits, {1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0});
        chk("held_cnt",  68'(frame_cnt), 68'd2);

        // Reset at data bit 10 (sample 22 after START)
        do_reset();
        send_word(32'hA5A5_0F0F);
        capture(22, -1, '0, 0, bits, frm, nrdy);
        chk("mid_pre_bit10", 68'(ser_out), 68'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ser_out",   68'(ser_out),   68'd0);
        chk("mid_frame",     68'(ser_frame), 68'd0);
        chk("mid_busy",      68'(busy),      68'd0);
        chk("mid_cnt",       68'(frame_cnt), 68'd0);
        chk("mid_in_ready",  68'(in_ready),  68'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(32'h3C96_5AA5);
        capture(34, -1, '0, 0, bits, frm, nrdy);
        chk("post_bits",  bits, 68'({1'b1, 32'h3C96_5AA5, 1'b0}));
        chk("post_frame", 68'(frm), 68'd32);
        chk("post_cnt",   68'(frame_cnt), 68'd1);

        // Frame counter wrap
        force dut.frame_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt;
        #1;
        chk("wrap_pre", 68'(frame_cnt), 68'hFFFF_FFFF);
        @(negedge clk);
        send_word(32'h8000_0001);
        capture(34, -1, '0, 0, bits, frm, nrdy);
        chk("wrap_bits", bits, 68'({1'b1, 32'h8000_0001, 1'b0}));
        chk("wrap_cnt",  68'(frame_cnt), 68'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Word-to-bit serializer: accepts a parallel word over a valid/ready handshake and shifts it out on a one-bit line, framed by a start and a stop bit. It is the transmit end of the single-bit `d` path feeding the registered sampling flops in the design. Benches use it to drive framed serial stimulus into that path. It keeps a running count of completed frames for scoreboard correlation.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits; legal range 2..32.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  word to transmit; transmitted MSB first.
- `ser_out`  out  1  serial line.
- `ser_frame`  out  1  high exactly during the WIDTH data-bit cycles.
- `busy`  out  1  high in START, DATA and STOP.
- `frame_cnt`  out  32  number of completed frames; wraps modulo 2^32.

## Operation
- There are four states: IDLE, START, DATA and STOP.
- All outputs are registered, except `in_ready`. `in_ready` is decoded combinationally from state: it is 1 in IDLE and STOP, and 0 otherwise.
- A word is accepted when `in_valid && in_ready` is true at a rising edge.
- On acceptance, `in_data` is loaded into a WIDTH-bit shift register and the next state is START. `in_data` is ignored at all other times.
- IDLE: `ser_out`=0, `ser_frame`=0, `busy`=0. It stays in IDLE until a word is accepted.
- START: lasts one cycle. `ser_out`=1 (start bit), `ser_frame`=0. Next state is DATA; the bit counter is cleared.
- DATA: lasts WIDTH cycles. `ser_out` = current shift-register MSB and `ser_frame`=1. The register shifts left each cycle and the bit counter increments. When the counter reaches WIDTH-1, the next state is STOP.
- STOP: lasts one cycle. `ser_out`=0 (stop bit), `ser_frame`=0. On leaving STOP, `frame_cnt` increments by 1.
  - If a word is accepted in STOP, the next state is START, so frames go back to back.
  - Otherwise the next state is IDLE.
- Bit counter width is `$clog2(WIDTH)`. Its compare is against WIDTH-1; there is no wrap-dependent logic.
- `frame_cnt` is 32 bits. It wraps from 0xFFFF_FFFF to 0 with no flag.
- `in_valid` asserted while `in_ready`=0 has no effect. The held word is taken at the next IDLE or STOP cycle.
- Reset asserted at any time has immediate effect on all registers:
  - state returns to IDLE, `ser_out`=0, `ser_frame`=0, `busy`=0 and `frame_cnt`=0;
  - the shift register and bit counter are cleared;
  - a partial frame is abandoned and not counted.

## Timing
- Reset values: `ser_out`=0, `ser_frame`=0, `busy`=0, `frame_cnt`=0, `in_ready`=1.
- With acceptance at edge E0:
  - the start bit is on `ser_out` in the cycle after E0;
  - data bit WIDTH-1 follows at E0+2 and bit 0 at E0+WIDTH+1;
  - the stop bit is at E0+WIDTH+2.
- `frame_cnt` updates at the edge that ends the STOP cycle.
- Frame length is WIDTH+2 cycles. Back-to-back throughput is one word per WIDTH+2 cycles, with no IDLE gap.
- Handshake: `in_ready` never depends on `in_valid`, so there is no combinational loop.
- Reset release is treated as synchronous to `clk` externally. The first possible acceptance is the first rising edge with `rst_n`=1.

## Test plan
- Reset check: hold `rst_n`=0 for 3 cycles, then release. Required: `ser_out`=0, `busy`=0, `frame_cnt`=0, `in_ready`=1.
- Single frame, WIDTH=32, word 0xA5A5_0F0F. Required:
  - `ser_out` sequence is 1, then 1010_0101_1010_0101_0000_1111_0000_1111, then 0;
  - `ser_frame` is high for exactly 32 cycles;
  - `frame_cnt` is 1 afterwards;
  - `in_ready` is 0 for 33 cycles.
- Back-to-back: keep `in_valid`=1 with words 0x0000_0001 then 0xFFFF_FFFF. Required: the second start bit immediately follows the first stop bit (68 cycles total for both frames) and `frame_cnt`=2.
- Held valid while busy: change `in_data` during DATA while `in_valid`=1. Required: the current frame is unchanged, and the value held at the STOP cycle is the next word sent.
- Reset mid-frame: assert `rst_n`=0 at data bit 10. Required: outputs clear immediately and `frame_cnt` is unchanged (0). A new word after release transmits a complete, correct frame.
- Wrap: force `frame_cnt` to 0xFFFF_FFFF, then send one frame. Required: `frame_cnt`=0.
